// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   state_e    : controller state (IDLE, RUN, DONE)
//   BOOTH_*    : opcode values of the {Q[0], q_1} pair examined each step
//   WIDTH_DEF  : default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam int WIDTH_DEF = 32;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration on WIDTH+1-bit registers.
//   acc, q, q_1, m      : current accumulator, multiplier, guard bit, multiplicand
//   acc_nx, q_nx, q_1_nx: values after the optional add/sub and the
//                         arithmetic right shift of {acc, q, q_1}
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] q,
  input  logic           q_1,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] acc_nx,
  output logic [WIDTH:0] q_nx,
  output logic           q_1_nx
);

  logic [WIDTH:0] sum;

  // Arithmetic wraps at WIDTH+1 bits; operands are pre-extended by one bit
  // so the wrap never loses information.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      BOOTH_NOP: sum = acc;
      default:   sum = acc;
    endcase
  end

  assign acc_nx = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nx   = {sum[0], q[WIDTH:1]};
  assign q_1_nx = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
//   clk, reset (async, active low)
//   start, is_signed, value_a, value_b : request, sampled when not busy
//   busy  : operation in progress
//   done  : one-cycle pulse, hi/low just updated
//   hi, low : full 2*WIDTH product, held until the next completion
// Fixed latency: WIDTH+1 steps after the start edge, no early exit.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] low
);

  localparam int CW = $clog2(WIDTH + 2);

  state_e          state;
  logic [WIDTH:0]  m, acc, q;
  logic            q_1;
  logic [CW-1:0]   count;
  logic [WIDTH:0]  acc_nx, q_nx;
  logic            q_1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .q      (q),
    .q_1    (q_1),
    .m      (m),
    .acc_nx (acc_nx),
    .q_nx   (q_nx),
    .q_1_nx (q_1_nx)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      hi    <= '0;
      low   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // One extra bit: sign copy when signed, zero when unsigned.
            m     <= {is_signed & value_a[WIDTH-1], value_a};
            q     <= {is_signed & value_b[WIDTH-1], value_b};
            acc   <= '0;
            q_1   <= 1'b0;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          q     <= q_nx;
          q_1   <= q_1_nx;
          count <= count + CW'(1);
          if (count == CW'(WIDTH)) begin
            // Product is the low 2*WIDTH bits of {acc_nx, q_nx}.
            hi    <= {acc_nx[WIDTH-2:0], q_nx[WIDTH]};
            low   <= q_nx[WIDTH-1:0];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        st32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int failures = 0;

  booth_mult_seq #(.WIDTH(32)) d32 (
    .clk(clk), .reset(reset), .start(st32), .is_signed(sg32),
    .value_a(a32), .value_b(b32), .busy(busy32), .done(done32),
    .hi(hi32), .low(lo32)
  );

  booth_mult_seq #(.WIDTH(8)) d8 (
    .clk(clk), .reset(reset), .start(st8), .is_signed(sg8),
    .value_a(a8), .value_b(b8), .busy(busy8), .done(done8),
    .hi(hi8), .low(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; returns at the
  // negedge of the done cycle.
  task automatic op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                    output logic [63:0] prod, output int edges, output int busyc);
    @(negedge clk);
    if (w8) begin st8 = 1'b1; sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin st32 = 1'b1; sg32 = sgn; a32 = a; b32 = b; end
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0; st32 = 1'b0;
    edges = 0; busyc = 0;
    while (!(w8 ? done8 : done32) && edges < 100) begin
      if (w8 ? busy8 : busy32) busyc++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    prod = w8 ? {48'd0, hi8, lo8} : {hi32, lo32};
  endtask

  initial begin
    logic [63:0] p;
    int          e, bc, n, latbad, seen;
    bit          held;
    logic [7:0]  v [8];
    int          sa, sb, ref_p;

    v = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_prod", {hi32, lo32}, 0);
    reset = 1'b1;

    // -3 * 7 signed: latency and busy window
    op(0, 1, 32'hFFFFFFFD, 32'd7, p, e, bc);
    chk("s_m3x7_prod", p, 64'hFFFFFFFF_FFFFFFEB);
    chk("s_m3x7_lat", e, 33);
    chk("s_m3x7_busyc", bc, 33);
    chk("busy_in_done", busy32, 0);
    chk("done_pulse", done32, 1);
    @(negedge clk);
    chk("done_one_cycle", done32, 0);

    op(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, p, e, bc);
    chk("u_max_sq", p, 64'hFFFFFFFE_00000001);
    op(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, p, e, bc);
    chk("s_m1_sq", p, 64'h00000000_00000001);
    op(0, 1, 32'h80000000, 32'h80000000, p, e, bc);
    chk("s_min_sq", p, 64'h40000000_00000000);
    op(0, 0, 32'h80000000, 32'd2, p, e, bc);
    chk("u_msb_x2", p, 64'h00000001_00000000);

    // start pulse mid-operation is ignored; outputs hold the previous result
    @(negedge clk);
    st32 = 1'b1; sg32 = 1'b0; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    st32 = 1'b0; held = 1'b1; n = 0;
    while (!done32 && n < 100) begin
      if (n == 4) begin st32 = 1'b1; sg32 = 1'b1; a32 = 32'd100; b32 = 32'd100; end
      else st32 = 1'b0;
      if (hi32 !== 32'd1 || lo32 !== 32'd0) held = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    st32 = 1'b0;
    chk("ign_hold", held, 1);
    chk("ign_lat", n, 33);
    chk("ign_prod", {hi32, lo32}, 64'd42);

    // back-to-back: start held during the DONE cycle
    st32 = 1'b1; sg32 = 1'b1; a32 = 32'hFFFFFFFE; b32 = 32'd3;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    st32 = 1'b0;
    chk("b2b_busy", busy32, 1);
    while (!done32 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("b2b_gap", n, 34);
    chk("b2b_prod", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFFA);

    // zero operand keeps fixed latency
    op(0, 1, 32'd0, 32'd12345, p, e, bc);
    chk("zero_prod", p, 64'd0);
    chk("zero_lat", e, 33);

    // asynchronous reset mid-operation
    @(negedge clk);
    st32 = 1'b1; sg32 = 1'b1; a32 = 32'd5; b32 = 32'hFFFFFFF7;
    @(posedge clk);
    @(negedge clk);
    st32 = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", busy32, 0);
    chk("arst_done", done32, 0);
    chk("arst_prod", {hi32, lo32}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (done32 || busy32) seen = 1;
    end
    chk("arst_no_done", seen, 0);
    op(0, 1, 32'd5, 32'hFFFFFFF7, p, e, bc);
    chk("post_rst_prod", p, 64'hFFFFFFFF_FFFFFFD3);
    chk("post_rst_lat", e, 33);

    // WIDTH=8 corner-value cross product in both modes
    latbad = 0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          op(1, s[0], {24'd0, v[i]}, {24'd0, v[j]}, p, e, bc);
          sa = s[0] ? int'($signed(v[i])) : int'(v[i]);
          sb = s[0] ? int'($signed(v[j])) : int'(v[j]);
          ref_p = sa * sb;
          chk($sformatf("w8_s%0d_%h_%h", s, v[i], v[j]), p, {48'd0, ref_p[15:0]});
          if (e != 9) latbad++;
        end
      end
    end
    chk("w8_lat", latbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
